// File: rtl/alu_seq_core.sv
// Registered, handshaked ALU with accumulator operand, full flags and bit-serial shifts.
// Optional ALU_SAT_EN: arithmetic results saturate on signed overflow instead of wrapping.
module alu_seq_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] result_q, sh_q;
    logic [SHW-1:0]   cnt_q;
    logic             dir_q;
    logic             carry_q, ovf_q, zero_q, neg_q, out_valid_q, busy_q;

    logic [WIDTH-1:0] opa, x, y, res_d, sh_d;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             cin, carry_d, ovf_d, accept, go_exec, sh_out;

    assign in_ready = !reset && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign opa      = use_acc ? result_q : a;
    assign shamt    = b[SHW-1:0];
    assign go_exec  = mode && (oper[2:1] == 2'b11) && (shamt != '0);

    // Shift datapath moves one bit per cycle; the result register keeps the old acc meanwhile.
    assign sh_d   = dir_q ? (sh_q >> 1) : (sh_q << 1);
    assign sh_out = dir_q ? sh_q[0] : sh_q[WIDTH-1];

    always_comb begin
        x   = opa;
        y   = '0;
        cin = 1'b0;
        case (oper)
            3'b000: y = b;
            3'b001: begin y = ~b; cin = 1'b1; end
            3'b010: y = ~b;
            3'b011: begin y = b; cin = 1'b1; end
            3'b100: cin = 1'b1;
            3'b101: y = '1;
            3'b110: begin x = b; cin = 1'b1; end
            default: begin x = b; y = '1; end
        endcase
        sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        res_d   = opa;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        if (!mode) begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
`ifdef ALU_SAT_EN
            if (ovf_d)
                res_d = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end else begin
            case (oper)
                3'b000: res_d = opa & b;
                3'b001: res_d = ~opa;
                3'b010: res_d = ~b;
                3'b011: res_d = opa | b;
                3'b100: res_d = opa ^ b;
                3'b101: res_d = ~(opa & b);
                default: res_d = opa;   // zero-length shift passes A through
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (go_exec) begin
                            sh_q        <= opa;
                            cnt_q       <= shamt;
                            dir_q       <= oper[0];
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= EXEC;
                        end else begin
                            result_q    <= res_d;
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            zero_q      <= (res_d == '0);
                            neg_q       <= res_d[WIDTH-1];
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else if (state_q == DONE && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                EXEC: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        result_q    <= sh_d;
                        carry_q     <= sh_out;
                        ovf_q       <= 1'b0;
                        zero_q      <= (sh_d == '0);
                        neg_q       <= sh_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed plus random checks of alu_seq_core against an arithmetic reference model.
module tb_alu_seq_core;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk, reset, in_valid, in_ready, mode, use_acc;
    logic         out_valid, out_ready, carry, overflow, zero, negative, busy;
    logic [2:0]   oper;
    logic [W-1:0] a, b, result;

    int n_vec = 0, n_fail = 0;
    int macc = 0, m_c = 0, m_v = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .oper(oper), .a(a), .b(b), .use_acc(use_acc),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .overflow(overflow), .zero(zero), .negative(negative),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= (1 << (W-1))) ? v - (1 << W) : v;
    endfunction

    // Reference: operation semantics in plain integer arithmetic.
    task automatic model(input int m, input int o, input int av, input int bv,
                         output int res, output int c, output int v, output int lat);
        int x, y, cin, s, sv, n;
        n = bv % W;
        c = 0; v = 0; lat = 1; res = 0;
        if (m == 0) begin
            x = av; y = 0; cin = 0;
            case (o)
                0: y = bv;
                1: begin y = ~bv & MASK; cin = 1; end
                2: y = ~bv & MASK;
                3: begin y = bv; cin = 1; end
                4: cin = 1;
                5: y = MASK;
                6: begin x = bv; cin = 1; end
                default: begin x = bv; y = MASK; end
            endcase
            s   = x + y + cin;
            res = s & MASK;
            c   = (s >> W) & 1;
            sv  = sgn(x) + sgn(y) + cin;
            v   = (sv > (1 << (W-1)) - 1 || sv < -(1 << (W-1))) ? 1 : 0;
`ifdef ALU_SAT_EN
            if (v) res = (x >= (1 << (W-1))) ? (1 << (W-1)) : (1 << (W-1)) - 1;
`endif
        end else begin
            case (o)
                0: res = av & bv;
                1: res = ~av & MASK;
                2: res = ~bv & MASK;
                3: res = av | bv;
                4: res = av ^ bv;
                5: res = ~(av & bv) & MASK;
                6: begin res = (av << n) & MASK; c = n ? (av >> (W-n)) & 1 : 0; lat = n + 1; end
                default: begin res = av >> n; c = n ? (av >> (n-1)) & 1 : 0; lat = n + 1; end
            endcase
        end
    endtask

    task automatic op(input int m, input int o, input int av, input int bv, input int u, input bit hold);
        int A, er, ec, ev, el, lat, waitc;
        A = u ? macc : av;
        model(m, o, A, bv, er, ec, ev, el);
        mode = m[0]; oper = o[2:0]; a = av[W-1:0]; b = bv[W-1:0]; use_acc = u[0];
        out_ready = 1'b1; in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 100) begin @(posedge clk); #1; waitc++; end
        check("in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("exec_busy", busy, 1);
            check("exec_in_ready", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid", out_valid, 1);
        check("latency", lat, el);
        check("result", result, er);
        check("carry", carry, ec);
        check("overflow", overflow, ev);
        check("zero", zero, (er == 0));
        check("negative", negative, (er >> (W-1)) & 1);
        check("done_busy", busy, 0);
        macc = er; m_c = ec; m_v = ev;
        if (hold) out_ready = 1'b0;
        else begin
            @(posedge clk); #1;
            check("back_idle", out_valid, 0);
        end
    endtask

    initial begin
        int A, er, ec, ev, el, o, av, bv, u;
        clk = 0; reset = 1; in_valid = 0; mode = 0; oper = 0;
        a = 0; b = 0; use_acc = 0; out_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry, overflow, zero, negative}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        reset = 0; #1;
        check("rel_in_ready", in_ready, 1);

        op(0, 0, 'h7F, 'h01, 0, 0);
`ifdef ALU_SAT_EN
        check("s2_sat", result, 'h7F);
`else
        check("s2_wrap", result, 'h80);
`endif
        op(0, 1, 'h05, 'h05, 0, 0);
        check("s3_sub_eq", result, 'h00);
        op(0, 1, 'h03, 'h05, 0, 0);
        check("s3_sub_neg", result, 'hFE);
        op(1, 6, 'h81, 'h03, 0, 0);
        check("s4_shl", result, 'h08);
        op(1, 7, 'h03, 'h01, 0, 0);
        check("s4_shr", result, 'h01);
        op(0, 4, 'hAA, 'h00, 1, 0);
        check("s5_acc_inc", result, 'h02);

        // Four back-to-back single-cycle ops, one result per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            o = $urandom_range(0, 7); av = $urandom_range(0, MASK);
            bv = $urandom_range(0, MASK); u = $urandom_range(0, 1);
            A = u ? macc : av;
            model(0, o, A, bv, er, ec, ev, el);
            mode = 0; oper = o[2:0]; a = av[W-1:0]; b = bv[W-1:0]; use_acc = u[0];
            in_valid = 1'b1;
            check("b2b_in_ready", in_ready, 1);
            @(posedge clk); #1;
            check("b2b_valid", out_valid, 1);
            check("b2b_result", result, er);
            check("b2b_carry", carry, ec);
            check("b2b_ovf", overflow, ev);
            macc = er;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drain", out_valid, 0);

        for (int k = 0; k < 40; k++)
            op($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, MASK),
               $urandom_range(0, MASK), $urandom_range(0, 1), 0);

        // Stall in DONE, then reset in the middle of a long shift.
        op(0, 0, $urandom_range(0, MASK), $urandom_range(0, MASK), 0, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, macc);
            check("hold_carry", carry, m_c);
            check("hold_ovf", overflow, m_v);
            check("hold_zero", zero, (macc == 0));
            check("hold_in_ready", in_ready, 0);
        end
        mode = 1; oper = 3'b111; a = 'h80; b = 'h07; use_acc = 0;
        in_valid = 1'b1; out_ready = 1'b1; #1;
        check("shr7_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("shr7_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        check("shr7_busy3", busy, 1);
        reset = 1'b1; #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {carry, overflow, zero, negative}, 0);
        reset = 1'b0; macc = 0; #1;
        check("post_rst_in_ready", in_ready, 1);
        op(0, 4, 'h55, 'h00, 1, 0);
        check("post_rst_acc", result, 'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised, registered successor to the 6-bit combinational ALU. It keeps the same {mode, oper} 16-operation map and adds:
- valid/ready handshakes on input and output
- an accumulator operand
- full flag set (carry, signed overflow, zero, negative), all computed from the registered result
- multi-cycle barrel-less shifts

It sits between the instruction decoder and the register file, so the datapath can be stalled.

Parameters:
WIDTH, 8, operand/result width; power of 2, >= 4.
SHW, $clog2(WIDTH), derived shift-amount width; do not override.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation this cycle
mode  input  1  0 = arithmetic, 1 = logic/shift
oper  input  3  operation select within mode
a  input  WIDTH  operand A
b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts
use_acc  input  1  1 = accumulator replaces operand A
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result; also the accumulator
carry  output  1  carry-out / last shifted-out bit
overflow  output  1  two's-complement overflow
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
busy  output  1  multi-cycle shift in progress

Behaviour:
- Reset: reset is synchronous, active-high. On the next edge: state=IDLE, result/acc=0, all flags=0, out_valid=0, busy=0. in_ready=0 while reset is high.
- Reset mid-operation (EXEC or DONE): the operation and any unconsumed result are discarded. No output handshake occurs.
- FSM states: IDLE, EXEC, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready. Operands, op and use_acc are captured on accept.
- Single-cycle ops: all except SHL/SHR, and shifts with shamt=0. Result and flags are registered on the accept edge, giving DONE with out_valid=1 the next cycle (latency 1). Back-to-back accepts in DONE with out_ready=1 give throughput 1 op/cycle.
- Shifts with shamt>0 go to EXEC. busy=1. One bit is shifted per cycle for shamt cycles, then DONE. out_valid rises shamt+1 cycles after accept.
- DONE: result and flags are held stable while out_ready=0. If out_ready=1 with no new accept, the block returns to IDLE and out_valid=0. result/acc keep their last value after the handshake.
- Arithmetic (mode=0) is computed as X+Y+cin in WIDTH+1 bits:
  - 000: A + B (X=A, Y=B, cin=0)
  - 001: A - B (X=A, Y=~B, cin=1)
  - 010: A + ~B (X=A, Y=~B, cin=0)
  - 011: A + B + 1 (X=A, Y=B, cin=1)
  - 100: A + 1 (X=A, Y=0, cin=1)
  - 101: A - 1 (X=A, Y=all-ones, cin=0)
  - 110: B + 1 (X=B, Y=0, cin=1)
  - 111: B - 1 (X=B, Y=all-ones, cin=0)
  - carry = bit WIDTH of the sum; for subtraction, carry=1 means no borrow.
  - overflow = (X[msb]==Y[msb]) && (R[msb]!=X[msb]).
- Logic (mode=1):
  - 000 AND, 001 ~A, 010 ~B, 011 OR, 100 XOR, 101 NAND
  - 110 SHL logical, 111 SHR logical, by b[SHW-1:0]
  - carry=0 and overflow=0 for logic ops.
  - For shifts, carry = last bit shifted out (0 if shamt=0); overflow=0.
- zero and negative are derived from the final result value that is presented, never from the previous result.
- "A" means acc when use_acc=1, captured at accept. acc equals the most recently completed result.

Optional Feature:
ALU_SAT_EN
- Defined: mode-0 ops saturate. On overflow, result = 0111..1 if X was non-negative, else 1000..0. overflow=1 is still reported. carry is unchanged. zero/negative follow the saturated value.
- Undefined: results wrap modulo 2^WIDTH.

Test Plan (WIDTH=8):
1. Reset 2 cycles, then release -> result=0x00, all flags 0, out_valid=0, busy=0; in_ready=1 on the first cycle after release.
2. mode0/000, a=0x7F, b=0x01 -> one cycle after accept: result=0x80, overflow=1, carry=0, negative=1, zero=0. With ALU_SAT_EN: result=0x7F, overflow=1, negative=0.
3. mode0/001, a=0x05, b=0x05 -> result=0x00, zero=1, carry=1, overflow=0. Then a=0x03, b=0x05 -> result=0xFE, carry=0, negative=1.
4. mode1/110, a=0x81, b=0x03 -> busy=1 and in_ready=0 for 3 cycles; out_valid 4 cycles after accept with result=0x08, carry=0. Then mode1/111, a=0x03, b=0x01 -> result=0x01, carry=1.
5. After step 4 (acc=0x01), use_acc=1, mode0/100, a=0xAA -> result=0x02 (a ignored). Issue 4 back-to-back single-cycle ops with out_ready=1 -> 4 results on 4 consecutive cycles.
6. Hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0. Then accept SHR with shamt=7, assert reset at cycle 3 of EXEC -> next cycle: out_valid=0, result=0, busy=0; in_ready=1 after release.
